// File: rtl/load_writeback_unit.sv
// load_writeback_unit
//   Final pipeline stage in front of the register-file write port. ALU results
//   retire in one cycle. RV32I loads go through a request/response data-memory
//   handshake with byte/halfword extraction and sign/zero extension. Misaligned
//   addresses, illegal load types and memory timeouts are reported as pulses.
//
// Ports:
//   clk, reset             clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready    retire request handshake (ready only in IDLE)
//   req_is_load            1 = load, 0 = ALU result writeback
//   req_funct3             load type (LB/LH/LW/LBU/LHU)
//   req_rd_addr            destination register
//   req_value              ALU result or load effective address
//   mem_req_valid/ready    data-memory read request handshake
//   mem_addr               word-aligned read address
//   mem_resp_valid/data    read response, full aligned word
//   rf_write_*             registered register-file write port
//   error_*                registered single-cycle error pulses
module load_writeback_unit #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_TIMEOUT    = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_is_load,
    input  logic [2:0]                req_funct3,
    input  logic [REG_ADDR_WIDTH-1:0] req_rd_addr,
    input  logic [DATA_WIDTH-1:0]     req_value,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [DATA_WIDTH-1:0]     mem_addr,
    input  logic                      mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]     mem_resp_data,
    output logic                      rf_write_enable,
    output logic [3:0]                rf_write_width,
    output logic [REG_ADDR_WIDTH-1:0] rf_write_reg_addr,
    output logic [DATA_WIDTH-1:0]     rf_write_data,
    output logic                      error_misaligned,
    output logic                      error_illegal,
    output logic                      error_timeout
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        MEM_REQ,
        MEM_WAIT
    } state_t;

    state_t state, next_state;

    logic [CNT_W-1:0]          wait_cnt;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic [2:0]                funct3_q;
    logic [1:0]                off_q;

    logic accept;
    logic is_legal;
    logic is_aligned;
    logic timeout_hit;

    logic                      we_nxt;
    logic [3:0]                width_nxt;
    logic [REG_ADDR_WIDTH-1:0] waddr_nxt;
    logic [DATA_WIDTH-1:0]     data_nxt;
    logic                      mis_nxt;
    logic                      ill_nxt;
    logic                      to_nxt;

    logic [DATA_WIDTH-1:0]     byte_shift;
    logic [DATA_WIDTH-1:0]     half_shift;
    logic [7:0]                sel_byte;
    logic [15:0]               sel_half;

    assign req_ready     = (state == IDLE);
    assign mem_req_valid = (state == MEM_REQ);
    assign accept        = req_valid & req_ready;
    assign timeout_hit   = (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

    // Request decode: legality and alignment of the incoming load.
    always_comb begin
        is_legal   = 1'b0;
        is_aligned = 1'b0;
        case (req_funct3)
            3'b000, 3'b100: begin
                is_legal   = 1'b1;
                is_aligned = 1'b1;
            end
            3'b001, 3'b101: begin
                is_legal   = 1'b1;
                is_aligned = ~req_value[0];
            end
            3'b010: begin
                is_legal   = 1'b1;
                is_aligned = (req_value[1:0] == 2'b00);
            end
            default: begin
                is_legal   = 1'b0;
                is_aligned = 1'b0;
            end
        endcase
    end

    // Lane selection from the aligned response word using the latched offset.
    assign byte_shift = mem_resp_data >> {off_q, 3'b000};
    assign half_shift = mem_resp_data >> {off_q[1], 4'b0000};
    assign sel_byte   = byte_shift[7:0];
    assign sel_half   = half_shift[15:0];

    // State register, request latches, wait counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            wait_cnt          <= '0;
            rd_q              <= '0;
            funct3_q          <= '0;
            off_q             <= '0;
            mem_addr          <= '0;
            rf_write_enable   <= 1'b0;
            rf_write_width    <= '0;
            rf_write_reg_addr <= '0;
            rf_write_data     <= '0;
            error_misaligned  <= 1'b0;
            error_illegal     <= 1'b0;
            error_timeout     <= 1'b0;
        end else begin
            state <= next_state;

            if (accept) begin
                rd_q     <= req_rd_addr;
                funct3_q <= req_funct3;
                off_q    <= req_value[1:0];
                mem_addr <= {req_value[DATA_WIDTH-1:2], 2'b00};
            end

            if (state == MEM_REQ && mem_req_ready) begin
                wait_cnt <= '0;
            end else if (state == MEM_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            rf_write_enable  <= we_nxt;
            error_misaligned <= mis_nxt;
            error_illegal    <= ill_nxt;
            error_timeout    <= to_nxt;

            // Payload only moves on a real write; otherwise it holds.
            if (we_nxt) begin
                rf_write_width    <= width_nxt;
                rf_write_reg_addr <= waddr_nxt;
                rf_write_data     <= data_nxt;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept && req_is_load && is_legal && is_aligned) begin
                    next_state = MEM_REQ;
                end
            end
            MEM_REQ: begin
                if (mem_req_ready) begin
                    next_state = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (mem_resp_valid || timeout_hit) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Output logic: values loaded into the registered outputs next edge.
    always_comb begin
        we_nxt    = 1'b0;
        width_nxt = 4'd4;
        waddr_nxt = rd_q;
        data_nxt  = mem_resp_data;
        mis_nxt   = 1'b0;
        ill_nxt   = 1'b0;
        to_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!req_is_load) begin
                        we_nxt    = (req_rd_addr != '0);
                        waddr_nxt = req_rd_addr;
                        data_nxt  = req_value;
                    end else if (!is_legal) begin
                        ill_nxt = 1'b1;
                    end else if (!is_aligned) begin
                        mis_nxt = 1'b1;
                    end
                end
            end
            MEM_WAIT: begin
                if (mem_resp_valid) begin
                    we_nxt = (rd_q != '0);
                    case (funct3_q)
                        3'b000: data_nxt = {{(DATA_WIDTH-8){sel_byte[7]}}, sel_byte};
                        3'b001: data_nxt = {{(DATA_WIDTH-16){sel_half[15]}}, sel_half};
                        3'b100: begin
                            width_nxt = 4'd1;
                            data_nxt  = {{(DATA_WIDTH-8){1'b0}}, sel_byte};
                        end
                        3'b101: begin
                            width_nxt = 4'd2;
                            data_nxt  = {{(DATA_WIDTH-16){1'b0}}, sel_half};
                        end
                        default: data_nxt = mem_resp_data;
                    endcase
                end else if (timeout_hit) begin
                    to_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
